// File: rtl/tdm8_slot_demux_if.sv
// Link and frame-output bundle for the 8-channel TDM receive demux.
// Optional parity signals appear when TDM_PARITY_EN is defined.
interface tdm8_slot_demux_if #(
  parameter int W = 4
);

  logic [W-1:0]   din;
  logic           din_valid;
  logic           frame_sync;
  logic [8*W-1:0] ch_out;
  logic           frame_valid;
  logic           sync_err;
  logic           locked;
  logic [2:0]     slot;
`ifdef TDM_PARITY_EN
  logic           din_par;
  logic           par_err;
`endif

  // master is the link/consumer side, slave is the demux itself
  modport master (
`ifdef TDM_PARITY_EN
    output din_par,
    input  par_err,
`endif
    output din,
    output din_valid,
    output frame_sync,
    input  ch_out,
    input  frame_valid,
    input  sync_err,
    input  locked,
    input  slot
  );

  modport slave (
`ifdef TDM_PARITY_EN
    input  din_par,
    output par_err,
`endif
    input  din,
    input  din_valid,
    input  frame_sync,
    output ch_out,
    output frame_valid,
    output sync_err,
    output locked,
    output slot
  );

endinterface

// File: rtl/tdm8_slot_demux.sv
// Receive-side 8-channel TDM demux: hunts for frame_sync, assembles slots into a shadow frame
// and publishes complete frames atomically. Define TDM_PARITY_EN to add per-beat even-parity checking.
module tdm8_slot_demux #(
  parameter int W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  tdm8_slot_demux_if.slave    bus
);

  typedef enum logic [0:0] {
    HUNT    = 1'b0,
    RECEIVE = 1'b1
  } state_t;

  state_t         r_state;
  logic [2:0]     r_slot;
  logic [8*W-1:0] r_shadow;
  logic [8*W-1:0] r_chOut;
  logic           r_frameValid;
  logic           r_syncErr;
  logic [8*W-1:0] w_fullFrame;

  // The slot-7 beat is merged directly so ch_out updates on the same edge it arrives
  assign w_fullFrame = {bus.din, r_shadow[7*W-1:0]};

`ifdef TDM_PARITY_EN
  logic r_frameBad;
  logic r_parErr;
  logic w_parBad;

  assign w_parBad    = (^bus.din) != bus.din_par;
  assign bus.par_err = r_parErr;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= HUNT;
      r_slot       <= 3'd0;
      r_shadow     <= '0;
      r_chOut      <= '0;
      r_frameValid <= 1'b0;
      r_syncErr    <= 1'b0;
`ifdef TDM_PARITY_EN
      r_frameBad   <= 1'b0;
      r_parErr     <= 1'b0;
`endif
    end else begin
      r_frameValid <= 1'b0;
      r_syncErr    <= 1'b0;
`ifdef TDM_PARITY_EN
      r_parErr     <= 1'b0;
`endif
      if (bus.din_valid) begin
        unique case (r_state)
          HUNT: begin
            if (bus.frame_sync) begin
              r_shadow[W-1:0] <= bus.din;
              r_slot          <= 3'd1;
              r_state         <= RECEIVE;
`ifdef TDM_PARITY_EN
              r_frameBad      <= 1'b0;
`endif
            end
          end

          RECEIVE: begin
            if (bus.frame_sync) begin
              // Sync anywhere but slot 0 restarts the frame on this beat
              r_syncErr       <= (r_slot != 3'd0);
              r_shadow[W-1:0] <= bus.din;
              r_slot          <= 3'd1;
`ifdef TDM_PARITY_EN
              r_frameBad      <= w_parBad;
`endif
            end else if (r_slot == 3'd0) begin
              r_syncErr <= 1'b1;
              r_state   <= HUNT;
            end else if (r_slot == 3'd7) begin
              r_shadow[7*W +: W] <= bus.din;
              r_slot             <= 3'd0;
`ifdef TDM_PARITY_EN
              if (r_frameBad || w_parBad) begin
                r_parErr <= 1'b1;
              end else begin
                r_chOut      <= w_fullFrame;
                r_frameValid <= 1'b1;
              end
`else
              r_chOut      <= w_fullFrame;
              r_frameValid <= 1'b1;
`endif
            end else begin
              r_shadow[int'(r_slot)*W +: W] <= bus.din;
              r_slot                        <= r_slot + 3'd1;
`ifdef TDM_PARITY_EN
              r_frameBad                    <= r_frameBad | w_parBad;
`endif
            end
          end

          default: begin
            r_state <= HUNT;
            r_slot  <= 3'd0;
          end
        endcase
      end
    end
  end

  assign bus.ch_out      = r_chOut;
  assign bus.frame_valid = r_frameValid;
  assign bus.sync_err    = r_syncErr;
  assign bus.locked      = (r_state == RECEIVE);
  assign bus.slot        = r_slot;

endmodule

// File: doc/tdm8_slot_demux.md
Name: tdm8_slot_demux

Overview:
- Receive end of the team's 8-channel time-division link.
- The transmit side drives one W-bit slot per valid beat, channel 0 first, and marks channel 0 with frame_sync.
- This block hunts for frame alignment and steers each beat into its channel slot, the sequential counterpart of the 1:8 demux.
- It publishes a complete 8-channel frame atomically with a one-cycle valid pulse. It sits between the serial link front end and the parallel channel consumers.

Parameters:
- W, 4, width of one channel slot in bits (1..32).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- din  input  W  slot data for the current beat.
- din_valid  input  1  beat qualifier; din and frame_sync are sampled only when it is high.
- frame_sync  input  1  high on the beat carrying channel 0.
- ch_out  output  8*W  last complete frame; channel k occupies bits [k*W +: W].
- frame_valid  output  1  one-cycle pulse when ch_out has been updated.
- sync_err  output  1  one-cycle pulse on an alignment violation.
- locked  output  1  high while the state machine is in RECEIVE.
- slot  output  3  index of the next expected slot (0..7).

Behaviour:
- Reset (async, rst_n=0): state=HUNT, slot=0, shadow register=0, ch_out=0, frame_valid=0, sync_err=0, locked=0.
- Beats with din_valid=0 are ignored entirely. State, slot and shadow are held.
- HUNT state:
  - Beat with frame_sync=0 is discarded.
  - Beat with frame_sync=1: din goes to shadow slot 0, slot becomes 1, next state is RECEIVE.
- RECEIVE state, slot 1..6:
  - frame_sync=0: din goes to shadow[slot], slot increments.
- RECEIVE state, slot 7, frame_sync=0:
  - din goes to shadow[7].
  - On the next clock edge, ch_out takes the full shadow with din in slot 7.
  - frame_valid=1 for exactly that one cycle. Latency is one clock from the slot-7 beat edge to frame_valid.
  - slot becomes 0 and the state stays RECEIVE.
- RECEIVE state, slot 0:
  - frame_sync=1: capture to shadow[0], slot becomes 1 (normal frame boundary).
  - frame_sync=0: sync_err pulse, discard the beat, go to HUNT with slot=0.
- RECEIVE state, frame_sync=1 at slot 1..7 (early sync):
  - sync_err pulse and discard the partial frame; ch_out is not updated.
  - Treat this beat as a new slot 0: shadow[0]=din, slot=1, stay RECEIVE.
- Back-to-back frames with no idle beats are supported. frame_valid pulses every 8 valid beats.
- ch_out holds its value between frames. A partial frame never reaches ch_out.
- Reset mid-frame drops the shadow contents immediately. The next frame requires a fresh frame_sync.
- frame_valid and sync_err are never high in the same cycle.

Optional Feature:
- Macro: TDM_PARITY_EN.
- Defined:
  - Adds input din_par (1 bit), the even parity of din, sampled with each beat.
  - Adds output par_err (1 bit), reset 0.
  - A beat with a parity mismatch in RECEIVE sets a sticky frame-bad flag, cleared at slot 0.
  - At slot-7 completion with the flag set: ch_out is not updated, frame_valid stays 0, and par_err pulses for one cycle. Lock is kept.
  - Parity is not checked in HUNT.
- Undefined: no din_par/par_err ports and no parity logic. Behaviour is exactly as above.

Test Plan:
- Test 1:
  - Stimulus: W=4, reset, then 8 consecutive beats with frame_sync on beat 0, din=0..7.
  - Response: one cycle after beat 7, frame_valid=1 and ch_out=32'h76543210; locked=1.
- Test 2:
  - Stimulus: same frame with din_valid deasserted for 3 cycles between beats 3 and 4.
  - Response: same ch_out, with frame_valid delayed by 3 cycles.
- Test 3:
  - Stimulus: frame 0..7, then a second frame with frame_sync re-asserted on its beat 5.
  - Response: sync_err pulse at that beat; ch_out stays 32'h76543210.
  - Follow-up: the next 7 beats 9..F complete a frame with ch_out = {F,E,D,C,B,A,9,restart din}.
- Test 4:
  - Stimulus: a complete frame, then beat 0 of the next frame without frame_sync.
  - Response: sync_err, locked=0, slot=0.
  - Follow-up: beats without sync are ignored until the next frame_sync.
- Test 5:
  - Stimulus: assert rst_n=0 at beat 4 of a frame, release, then send a clean frame of all A.
  - Response: ch_out=0 during reset, then 32'hAAAAAAAA with a single frame_valid.
- Test 6 (TDM_PARITY_EN):
  - Stimulus: send a frame with wrong din_par on slot 2.
  - Response: par_err pulse, no frame_valid, ch_out unchanged.
  - Follow-up: the next clean frame updates ch_out normally.
